alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, registered ALU for the datapath: a WIDTH-bit, 16-operation ARM-style integer unit with a persistent Z/N/C/V flag register, carry-in operations (ADC/SBC/RSC) and barrel shifts. One output register stage with valid/ready handshakes on both sides lets the unit sit between the decode/operand stage and writeback with full backpressure support. It replaces the combinational 32-bit ALU; op codes 0000 (ADD) and 0001 (SUB) keep their existing meaning.

## Interface
- WIDTH, 32, operand/result width in bits; legal range ≥ 2.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand bundle present
- in_ready  out  1  unit can accept; combinational = !out_valid | out_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; full value is the unsigned shift amount for shift ops
- op  in  4  operation code
- set_flags  in  1  update flag register with this op's flags
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- z, n, c, v  out  1 each  current flag register

## Operation
- Accept when in_valid & in_ready. On accept: result ← f(op), out_valid ← 1; if set_flags, flags ← computed flags, else flags unchanged.
- No accept and out_valid & out_ready: out_valid ← 0; result holds its last value.
- Ops (c_in = registered C): 0000 ADD a+b; 0001 SUB a−b; 0010 ADC a+b+c_in; 0011 SBC a−b−!c_in; 0100 RSB b−a; 0101 RSC b−a−!c_in; 0110 AND; 0111 OR; 1000 XOR; 1001 BIC a&~b; 1010 MOVA a; 1011 MOVB b; 1100 MVN ~b; 1101 LSL; 1110 LSR; 1111 ASR (shifts on a).
- Arithmetic: computed in WIDTH+1 bits. Add-type C = carry-out; subtract-type C = NOT borrow (1 when no borrow). V = signed overflow of the WIDTH-bit operation.
- Logic/move ops: C, V unchanged.
- Shifts, amount s = b unsigned: s=0 → result a, C unchanged; 1 ≤ s < WIDTH → normal shift, C = last bit shifted out (LSL a[WIDTH−s], LSR/ASR a[s−1]); s ≥ WIDTH → LSL/LSR result 0, C=0; ASR result all a[WIDTH−1], C=a[WIDTH−1]. V unchanged for shifts.
- Z = (result==0), N = result[WIDTH−1] for every op.
- Back-to-back carry chain: the flag register updates on the accept edge, so an op accepted on the next cycle sees the new C.

## Timing
- Latency 1: result/flags valid the cycle after accept; throughput 1 op/cycle when out_ready stays high.
- Reset: out_valid=0, result=0, z=n=c=v=0; in_ready=1 in the first cycle after reset.
- Stall: out_valid & !out_ready → in_ready=0; result, flags and out_valid held stable until the handshake.
- Simultaneous consume and accept in one cycle: new result loaded, out_valid stays 1.
- in_valid while in_ready=0 is ignored; the producer holds its inputs.
- Reset mid-operation discards a pending result and clears flags; reset wins over any simultaneous handshake.

## Structure
- Package alu_pkg: op-code enum (ADD … ASR), flag struct {z,n,c,v}.
- Sub-module alu_core: purely combinational f(a,b,op,c_in) → {result, flags_next}, parametrised by WIDTH; alu_pipe adds the handshake, result register and flag register.

## Test plan
- ADD a=0x9C000038 b=0x70000003 set_flags=1 → result 0x0C00003B, Z=0 N=0 C=1 V=0.
- SUB, same operands → 0x2C000035, Z=0 N=0 C=1 V=1; then ADC a=0xFFFFFFFF b=0 back-to-back → 0x00000000, Z=1 C=1 V=0.
- Shifts: ASR a=0x80000000 b=4 → 0xF8000000, C=0; LSL a=0x80000001 b=1 → 0x00000002, C=1; LSR b=40 → 0, C=0; LSL b=0 → a, C unchanged.
- Backpressure: out_ready=0 for 3 cycles after an accept → in_ready=0, result and flags stable; a second op is accepted in the cycle out_ready rises, out_valid stays 1.
- set_flags=0: AND a=0 b=0xFF after a flag-setting ADD → result 0, flags still equal the ADD's flags.
- Reset with out_valid=1 and flags set → next cycle out_valid=0, result=0, z=n=c=v=0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: op-code encoding and flag-register layout.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSub  = 4'b0001,
    OpAdc  = 4'b0010,
    OpSbc  = 4'b0011,
    OpRsb  = 4'b0100,
    OpRsc  = 4'b0101,
    OpAnd  = 4'b0110,
    OpOr   = 4'b0111,
    OpXor  = 4'b1000,
    OpBic  = 4'b1001,
    OpMova = 4'b1010,
    OpMovb = 4'b1011,
    OpMvn  = 4'b1100,
    OpLsl  = 4'b1101,
    OpLsr  = 4'b1110,
    OpAsr  = 4'b1111
  } op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  // Ops that route through the shared adder.
  function automatic logic is_arith(op_e o);
    return (o == OpAdd) || (o == OpSub) || (o == OpAdc) ||
           (o == OpSbc) || (o == OpRsb) || (o == OpRsc);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and next flags from operands, op and current flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic [3:0]       flags_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_next
);

  localparam int unsigned Msb = WIDTH - 1;
  localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);

  op_e            op_q;
  flags_t         fin;
  flags_t         fout;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             add_v;
  logic             shift_zero;
  logic             shift_big;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [WIDTH:0]   sar;

  assign op_q = op_e'(op);
  assign fin  = flags_t'(flags_in);

  // Subtract-type ops reuse the adder as x + ~y + cin so C comes out as NOT borrow.
  always_comb begin
    x   = a;
    y   = b;
    cin = 1'b0;
    unique case (op_q)
      OpSub:   begin y = ~b; cin = 1'b1;  end
      OpAdc:   begin cin = fin.c;         end
      OpSbc:   begin y = ~b; cin = fin.c; end
      OpRsb:   begin x = b; y = ~a; cin = 1'b1;  end
      OpRsc:   begin x = b; y = ~a; cin = fin.c; end
      default: begin end
    endcase
  end

  assign sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  assign add_v = (x[Msb] == y[Msb]) && (sum[Msb] != x[Msb]);

  // Extra guard bit on each shifter catches the last bit shifted out.
  assign shift_zero = (b == '0);
  assign shift_big  = (b >= WidthVal);
  assign shl        = {1'b0, a} << b;
  assign shr        = {a, 1'b0} >> b;
  assign sar        = $signed({a, 1'b0}) >>> b;

  always_comb begin
    result = '0;
    fout   = fin;
    if (is_arith(op_q)) begin
      result = sum[WIDTH-1:0];
      fout.c = sum[WIDTH];
      fout.v = add_v;
    end else begin
      unique case (op_q)
        OpAnd:  result = a & b;
        OpOr:   result = a | b;
        OpXor:  result = a ^ b;
        OpBic:  result = a & ~b;
        OpMova: result = a;
        OpMovb: result = b;
        OpMvn:  result = ~b;
        OpLsl: begin
          if (shift_zero) begin
            result = a;
          end else if (shift_big) begin
            result = '0;
            fout.c = 1'b0;
          end else begin
            result = shl[WIDTH-1:0];
            fout.c = shl[WIDTH];
          end
        end
        OpLsr: begin
          if (shift_zero) begin
            result = a;
          end else if (shift_big) begin
            result = '0;
            fout.c = 1'b0;
          end else begin
            result = shr[WIDTH:1];
            fout.c = shr[0];
          end
        end
        OpAsr: begin
          if (shift_zero) begin
            result = a;
          end else if (shift_big) begin
            result = {WIDTH{a[Msb]}};
            fout.c = a[Msb];
          end else begin
            result = sar[WIDTH:1];
            fout.c = sar[0];
          end
        end
        default: result = '0;
      endcase
    end
    fout.z = (result == '0);
    fout.n = result[Msb];
  end

  assign flags_next = fout;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU: one output stage with valid/ready on both sides and a persistent flag register.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  flags_t           flags_q;
  flags_t           flags_d;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;
  logic             accept;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a          (a),
    .b          (b),
    .op         (op),
    .flags_in   (flags_q),
    .result     (core_result),
    .flags_next (core_flags)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (accept) begin
      valid_d  = 1'b1;
      result_d = core_result;
      if (set_flags) begin
        flags_d = flags_t'(core_flags);
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign z         = flags_q.z;
  assign n         = flags_q.n;
  assign c         = flags_q.c;
  assign v         = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed ops push expected results, a monitor pops on handshake.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        set_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        z, n, c, v;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_pipe #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .n         (n),
    .c         (c),
    .v         (v)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one op and wait for acceptance; expected result goes to the scoreboard.
  task automatic issue(input string name, input logic [3:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic sf, input logic [31:0] er,
                       input logic [3:0] ef, input bit push);
    bit got = 0;
    in_valid  = 1'b1;
    op        = o;
    a         = aa;
    b         = bb;
    set_flags = sf;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s accept timeout: in_ready stayed 0 expected 1", name);
    end else if (push) begin
      sb.push_back('{name, er, ef});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every consumed output is compared against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected output: got %h expected none", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, " result"}, result, e.res);
          check({e.name, " flags"}, {28'd0, z, n, c, v}, {28'd0, e.fl});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    set_flags = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", {28'd0, z, n, c, v}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Flags shown as {z,n,c,v}; ADD/SUB/ADC back-to-back exercise the carry chain.
    issue("add", OpAdd, 32'h9C000038, 32'h70000003, 1, 32'h0C00003B, 4'b0010, 1);
    issue("sub", OpSub, 32'h9C000038, 32'h70000003, 1, 32'h2C000035, 4'b0011, 1);
    issue("adc", OpAdc, 32'hFFFFFFFF, 32'h00000000, 1, 32'h00000000, 4'b1010, 1);
    issue("asr", OpAsr, 32'h80000000, 32'd4,        1, 32'hF8000000, 4'b0100, 1);
    issue("lsl1", OpLsl, 32'h80000001, 32'd1,       1, 32'h00000002, 4'b0010, 1);
    issue("lsl0", OpLsl, 32'h80000001, 32'd0,       1, 32'h80000001, 4'b0110, 1);
    issue("lsr40", OpLsr, 32'h12345678, 32'd40,     1, 32'h00000000, 4'b1000, 1);
    issue("addv", OpAdd, 32'h7FFFFFFF, 32'd1,       1, 32'h80000000, 4'b0101, 1);
    issue("and_nf", OpAnd, 32'h0, 32'hFF,           0, 32'h00000000, 4'b0101, 1);
    issue("sbc", OpSbc, 32'd10, 32'd3,              1, 32'd6,        4'b0010, 1);
    issue("rsb", OpRsb, 32'd3, 32'd10,              1, 32'd7,        4'b0010, 1);
    issue("rsc", OpRsc, 32'd5, 32'd5,               1, 32'd0,        4'b1010, 1);
    issue("mvn", OpMvn, 32'h0, 32'h0,               1, 32'hFFFFFFFF, 4'b0110, 1);
    issue("or", OpOr, 32'hF0, 32'h0F,               1, 32'h000000FF, 4'b0010, 1);

    // Backpressure: hold the consumer off for three cycles.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue("mova", OpMova, 32'h11, 32'h0, 1, 32'h00000011, 4'b0010, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
      check("stall result", result, 32'h11);
      check("stall flags", {28'd0, z, n, c, v}, 32'h2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue("movb", OpMovb, 32'h0, 32'h22, 1, 32'h00000022, 4'b0010, 1);
    check("consume+accept out_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);

    // Reset discards a pending result with flags set.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue("add_rst", OpAdd, 32'h80000000, 32'h80000000, 1, 32'h0, 4'b1011, 0);
    @(negedge clk);
    check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    check("pre-reset flags", {28'd0, z, n, c, v}, 32'hB);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid-reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-reset result", result, 32'd0);
    check("mid-reset flags", {28'd0, z, n, c, v}, 32'd0);
    check("mid-reset in_ready", {31'd0, in_ready}, 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
